// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded MIPS fields into 32-bit instruction words and
// streams them from a small FIFO with sequential text-segment addresses.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int unsigned DEPTH     = 32'd4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  fmt,
  input  logic [5:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  func,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic [15:0] count
);

  localparam int unsigned AW = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;

  localparam logic [1:0]    FMT_R     = 2'd0;
  localparam logic [1:0]    FMT_I     = 2'd1;
  localparam logic [1:0]    FMT_J     = 2'd2;
  localparam logic [31:0]   ERET_WORD = 32'h4200_0018;
  localparam logic [AW:0]   FULL_OCC  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   OCC_ZERO  = (AW+1)'(1'b0);
  localparam logic [AW:0]   OCC_ONE   = (AW+1)'(1'b1);
  localparam logic [AW-1:0] PTR_ZERO  = (AW)'(1'b0);
  localparam logic [AW-1:0] PTR_ONE   = (AW)'(1'b1);

  // Field packing for each instruction format; ERET ignores every field.
  function automatic logic [31:0] encode_word(
    input logic [1:0]  f_fmt,
    input logic [5:0]  f_op,
    input logic [4:0]  f_rs,
    input logic [4:0]  f_rt,
    input logic [4:0]  f_rd,
    input logic [4:0]  f_shamt,
    input logic [5:0]  f_func,
    input logic [15:0] f_imm16,
    input logic [25:0] f_imm26
  );
    logic [31:0] w;
    case (f_fmt)
      FMT_R:   w = {6'b000000, f_rs, f_rt, f_rd, f_shamt, f_func};
      FMT_I:   w = {f_op, f_rs, f_rt, f_imm16};
      FMT_J:   w = {f_op, f_imm26};
      default: w = ERET_WORD;
    endcase
    return w;
  endfunction

  logic [31:0]   mem_r [0:DEPTH-1];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   occ_r;
  logic [15:0]   count_r;
  logic [31:0]   word_s;
  logic          push_s;
  logic          pop_s;

  assign word_s    = encode_word(fmt, op, rs, rt, rd, shamt, func, imm16, imm26);
  // No bypass: a full FIFO refuses a push even when a pop happens that cycle.
  assign in_ready  = (occ_r < FULL_OCC) && !clr;
  assign out_valid = (occ_r != OCC_ZERO) && !clr;
  assign push_s    = in_valid && in_ready;
  assign pop_s     = out_valid && out_ready;
  assign out_instr = (occ_r != OCC_ZERO) ? mem_r[rd_ptr_r] : 32'h0000_0000;
  assign out_addr  = BASE_ADDR + {14'd0, count_r, 2'b00};
  assign count     = count_r;

  // Word storage; only slots between rd_ptr and wr_ptr are ever observed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= word_s;
    end
  end

  // Pointer, occupancy and delivered-word counter; clr outranks push and pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      occ_r    <= OCC_ZERO;
      count_r  <= 16'd0;
    end else if (clr) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      occ_r    <= OCC_ZERO;
      count_r  <= 16'd0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
        count_r  <= count_r + 16'd1;
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_ONE;
        2'b01:   occ_r <= occ_r - OCC_ONE;
        default: occ_r <= occ_r;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: randomized and directed bundles checked
// against an arithmetic reference encoder and a queue model of the FIFO.
module tb_instr_encoder;

  localparam logic [31:0] BASE  = 32'h0000_3000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [1:0]  fmt = 2'd0;
  logic [5:0]  op = 6'd0;
  logic [4:0]  rs = 5'd0;
  logic [4:0]  rt = 5'd0;
  logic [4:0]  rd = 5'd0;
  logic [4:0]  shamt = 5'd0;
  logic [5:0]  func = 6'd0;
  logic [15:0] imm16 = 16'd0;
  logic [25:0] imm26 = 26'd0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_addr;
  logic [15:0] count;

  instr_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
    .func(func), .imm16(imm16), .imm26(imm26),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr), .count(count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  int unsigned m_count = 0;
  bit          exp_ready = 1'b0;
  bit          exp_valid = 1'b0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference encoder built from field positions with plain arithmetic.
  function automatic logic [31:0] ref_encode(input int unsigned f, input int unsigned o,
      input int unsigned s, input int unsigned t, input int unsigned d,
      input int unsigned sh, input int unsigned fn, input int unsigned i16,
      input int unsigned i26);
    int unsigned w;
    case (f)
      0:       w = s * 32'd2097152 + t * 32'd65536 + d * 32'd2048 + sh * 32'd64 + fn;
      1:       w = o * 32'd67108864 + s * 32'd2097152 + t * 32'd65536 + i16;
      2:       w = o * 32'd67108864 + i26;
      default: w = 32'h4200_0018;
    endcase
    return w;
  endfunction

  // Stimulus side of the scoreboard: record every accepted bundle's expected word.
  always @(posedge clk) begin
    if (mon_en && reset_n) begin
      if (clr) begin
        exp_q.delete();
        m_count = 0;
      end else if (in_valid && exp_ready) begin
        exp_q.push_back(ref_encode(fmt, op, rs, rt, rd, shamt, func, imm16, imm26));
      end
    end
  end

  // Monitor: compare handshake and head word against the model, pop on delivery.
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      exp_valid = (exp_q.size() != 0) && !clr;
      exp_ready = (exp_q.size() < DEPTH) && !clr;
      check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
      check("count", {16'd0, count}, m_count);
      check("out_addr", out_addr, BASE + m_count * 32'd4);
      if (exp_valid) check("out_instr", out_instr, exp_q[0]);
      else if (exp_q.size() == 0) check("out_instr_empty", out_instr, 32'h0);
      if (exp_valid && out_ready) begin
        void'(exp_q.pop_front());
        m_count = (m_count + 1) % 65536;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] f, input logic [5:0] o, input logic [4:0] s,
      input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
      input logic [5:0] fn, input logic [15:0] i16, input logic [25:0] i26);
    fmt = f; op = o; rs = s; rt = t; rd = d; shamt = sh;
    func = fn; imm16 = i16; imm26 = i26; in_valid = 1'b1;
  endtask

  task automatic drive_rand();
    drive(2'($urandom_range(0, 3)), 6'($urandom), 5'($urandom), 5'($urandom),
          5'($urandom), 5'($urandom), 6'($urandom), 16'($urandom), 26'($urandom));
  endtask

  task automatic do_clr();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && k < 50) begin
      cyc();
      k++;
    end
    @(negedge clk);
    check(name, {31'd0, out_valid}, 32'd0);
    cyc();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_addr", out_addr, BASE);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_count", {16'd0, count}, 32'd0);

    // R-type with a garbage opcode that must be ignored
    cyc();
    out_ready = 1'b1;
    drive(2'd0, 6'h15, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'hFFFF, 26'h3FF_FFFF);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    check("r_instr", out_instr, 32'h0022_1821);
    check("r_addr", out_addr, 32'h0000_3000);
    cyc();
    @(negedge clk);
    check("r_count", {16'd0, count}, 32'd1);

    // I then J back to back
    cyc();
    do_clr();
    drive(2'd1, 6'h0D, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0);
    cyc();
    drive(2'd2, 6'h03, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h000_0C00);
    @(negedge clk);
    check("i_instr", out_instr, 32'h3401_1234);
    check("i_addr", out_addr, 32'h0000_3000);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    check("j_instr", out_instr, 32'h0C00_0C00);
    check("j_addr", out_addr, 32'h0000_3004);

    // ERET with every field set to garbage
    cyc();
    drive(2'd3, 6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FF_FFFF);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    check("eret_instr", out_instr, 32'h4200_0018);
    cyc();

    // Backpressure: fill, refuse a 5th, refuse a push/pop at full, drain in order
    do_clr();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_rand();
      cyc();
    end
    @(negedge clk);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    check("full_addr", out_addr, 32'h0000_3000);
    cyc();
    out_ready = 1'b1;
    @(negedge clk);
    check("full_no_bypass", {31'd0, in_ready}, 32'd0);
    cyc();
    drain("bp_drain");

    // clr mid-stream with 3 words queued and count=5
    do_clr();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_rand();
      cyc();
    end
    drain("clr_pre_drain");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rand();
      cyc();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("clr_pre_count", {16'd0, count}, 32'd5);
    cyc();
    clr = 1'b1;
    drive_rand();
    cyc();
    clr = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("clr_out_valid", {31'd0, out_valid}, 32'd0);
    check("clr_count", {16'd0, count}, 32'd0);
    check("clr_addr", out_addr, BASE);

    // Asynchronous reset between edges with 2 words queued
    cyc();
    out_ready = 1'b0;
    drive_rand();
    cyc();
    drive_rand();
    cyc();
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    exp_q.delete();
    m_count = 0;
    exp_ready = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_addr", out_addr, BASE);
    cyc();
    cyc();
    reset_n = 1'b1;
    @(negedge clk);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_rel_addr", out_addr, BASE);

    // Randomized traffic with occasional clr
    for (int i = 0; i < 400; i++) begin
      cyc();
      if ($urandom_range(0, 3) != 0) drive_rand();
      else in_valid = 1'b0;
      out_ready = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 24) == 0);
    end
    cyc();
    clr = 1'b0;
    drain("rand_drain");

    // Counter wrap: 65535 deliveries, then one more
    do_clr();
    out_ready = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      drive_rand();
      cyc();
    end
    in_valid = 1'b0;
    repeat (4) cyc();
    @(negedge clk);
    check("wrap_count_max", {16'd0, count}, 32'h0000_FFFF);
    check("wrap_addr_max", out_addr, 32'h0004_2FFC);
    cyc();
    drive_rand();
    cyc();
    in_valid = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    check("wrap_count", {16'd0, count}, 32'd0);
    check("wrap_addr", out_addr, BASE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Inverse of the pipeline's instruction field decoder: accepts decoded MIPS fields (op, rs, rt, rd, shamt, func, imm16, imm26, or an eret request) over a valid/ready handshake and packs them into 32-bit instruction words. Words are buffered in a small FIFO and streamed out with sequential word addresses starting at the text-segment base. The block sits in the test/boot path and feeds instruction-memory preload or self-modifying-code stimulus for the P7 CPU.

## Interface

Parameters:
- BASE_ADDR, 32'h0000_3000, address of the first emitted word.
- DEPTH, 4, FIFO entries (power of two, 2..16).

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear: empties the FIFO and zeroes the word counter.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder can accept a bundle.
- fmt  input  2  0 = R, 1 = I, 2 = J, 3 = ERET.
- op  input  6  opcode (I/J only).
- rs, rt, rd, shamt  input  5 each  register and shift fields.
- func  input  6  R-type function code.
- imm16  input  16  I-type immediate.
- imm26  input  26  J-type index.
- out_valid  output  1  encoded word available.
- out_ready  input  1  consumer takes the word.
- out_instr  output  32  encoded word at FIFO head.
- out_addr  output  32  BASE_ADDR + 4*count.
- count  output  16  words delivered since reset/clr.

## Operation

- Encoding at push time:
  - R: {6'b0, rs, rt, rd, shamt, func}. The op input is ignored.
  - I: {op, rs, rt, imm16}.
  - J: {op, imm26}.
  - ERET: 32'h4200_0018. All field inputs are ignored.
- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- FIFO:
  - Circular buffer, DEPTH entries, with wr_ptr, rd_ptr and an occupancy counter of width log2(DEPTH)+1.
  - Pointers wrap modulo DEPTH.
- in_ready = (occupancy < DEPTH) && !clr. There is no bypass when full: a pop in the same cycle does not make room for a push.
- out_valid = (occupancy != 0) && !clr.
- out_instr is the head entry, or 0 when empty.
- Simultaneous push and pop: occupancy is unchanged and both pointers advance.
- count:
  - Increments by 1 on each pop and wraps at 16 bits.
  - out_addr = BASE_ADDR + {count, 2'b00}, truncated to 32 bits (combinational from count).
- clr:
  - Has priority over push and pop in the same cycle.
  - Next cycle: occupancy = 0, pointers = 0, count = 0.
  - Data presented during the clr cycle is discarded.
- Reset (reset_n low, any time, including mid-stream):
  - occupancy, pointers and count are 0.
  - Resulting outputs: out_valid = 0, out_instr = 0, out_addr = BASE_ADDR, in_ready = 1 once reset_n is high.
  - FIFO storage contents are don't-care.

## Timing

- Latency: a word pushed at edge N is on out_instr with out_valid = 1 after edge N (visible in cycle N+1). There is no combinational path from in_* to out_*.
- Throughput: 1 word per cycle when out_ready is held high.
- in_ready depends only on registered state and clr. out_ready does not combinationally affect in_ready.
- out_instr, out_addr and out_valid are stable while out_valid = 1 and out_ready = 0.
- A push in the cycle when occupancy = DEPTH-1 drives in_ready low in the next cycle, unless a pop occurs in the same cycle.
- Reset assertion clears state immediately (asynchronously). Release is synchronous to the next clk edge.

## Test plan

- R-type: fmt=0, rs=1, rt=2, rd=3, shamt=0, func=0x21, out_ready=1 -> next cycle out_instr=0x00221821, out_addr=0x00003000; after the pop, count=1.
- I and J back-to-back:
  - fmt=1, op=0x0D, rs=0, rt=1, imm16=0x1234 -> 0x34011234 at 0x3000.
  - Then fmt=2, op=0x03, imm26=0x0000C00 -> 0x0C000C00 at 0x3004.
- ERET with garbage fields: fmt=3, op=0x3F, rs=31 -> out_instr=0x42000018.
- Backpressure:
  - out_ready=0; push 4 words -> in_ready=0 after the 4th push, and a 5th in_valid is not accepted.
  - Then out_ready=1 -> the 4 words drain in order at addresses 0x3000, 0x3004, 0x3008, 0x300C.
  - A simultaneous push/pop at full is not accepted, because there is no bypass.
- clr mid-stream: 3 words queued, count=5, clr=1 with in_valid=1 -> next cycle out_valid=0, count=0, out_addr=0x3000, and the clr-cycle bundle is absent.
- Async reset: reset_n driven low between clock edges with 2 words queued -> out_valid falls immediately; after release, in_ready=1 and out_addr=0x3000.
- Wrap: force count to 0xFFFF via 65535 pops, then pop once more -> count=0 and out_addr=BASE_ADDR.
